// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/stall controller: forwarding select
// encodings, divider FSM state encoding and register-match helpers.
package hazard_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_W   = 2'b01;
    localparam logic [1:0] FWD_M   = 2'b10;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_DONE = 2'b10
    } div_state_t;

    // A producer only matches when it really writes a non-zero register.
    function automatic logic reg_match(input logic [4:0] src,
                                       input logic [4:0] dst,
                                       input logic       wr);
        return wr && (dst != 5'd0) && (dst == src);
    endfunction

    // E-stage operand select: the younger M result beats the older W result.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic [4:0] dst_m,
                                           input logic       wr_m,
                                           input logic [4:0] dst_w,
                                           input logic       wr_w);
        if (reg_match(src, dst_m, wr_m))
            return FWD_M;
        else if (reg_match(src, dst_w, wr_w))
            return FWD_W;
        else
            return FWD_REG;
    endfunction

endpackage

// File: rtl/div_stall_fsm.sv
// Holds the pipeline for the full latency of the iterative divider.
// busy covers the start cycle itself (combinational on start) plus every
// BUSY cycle, giving exactly DIV_CYCLES stall cycles per divide. The DONE
// cycle lets the divide leave E even while start is still high.
module div_stall_fsm #(
    parameter int DIV_CYCLES = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic abort,
    output logic busy
);
    import hazard_pkg::*;

    localparam int CW = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_CYCLES - 2);

    div_state_t     state;
    logic [CW-1:0]  cnt;

    // State and countdown; abort returns to IDLE from anywhere.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= DIV_IDLE;
            cnt   <= '0;
        end else if (abort) begin
            state <= DIV_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start) begin
                        state <= DIV_BUSY;
                        cnt   <= CNT_LOAD;
                    end
                end
                DIV_BUSY: begin
                    if (cnt == '0)
                        state <= DIV_DONE;
                    else
                        cnt <= cnt - 1'b1;
                end
                DIV_DONE: state <= DIV_IDLE;
                default:  state <= DIV_IDLE;
            endcase
        end
    end

    assign busy = ((state == DIV_IDLE) && start) || (state == DIV_BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller for the five-stage core: operand
// forwarding selects, load-use / branch stalls, divider hold and exception
// flush. Everything is combinational except the divider FSM.
module hazard_ctrl #(
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rs_d,
    input  logic [4:0] rt_d,
    input  logic [4:0] rs_e,
    input  logic [4:0] rt_e,
    input  logic [4:0] writereg_e,
    input  logic [4:0] writereg_m,
    input  logic [4:0] writereg_w,
    input  logic       regwrite_e,
    input  logic       regwrite_m,
    input  logic       regwrite_w,
    input  logic       memtoreg_e,
    input  logic       memtoreg_m,
    input  logic       branch_d,
    input  logic       div_start_e,
    input  logic       except_m,
    output logic       stall_f,
    output logic       stall_d,
    output logic       stall_e,
    output logic       stall_m,
    output logic       flush_d,
    output logic       flush_e,
    output logic       flush_m,
    output logic       flush_w,
    output logic       forward_a_d,
    output logic       forward_b_d,
    output logic [1:0] forward_a_e,
    output logic [1:0] forward_b_e,
    output logic       div_busy
);
    import hazard_pkg::*;

    logic lw_stall;
    logic br_stall;
    logic div_stall;

    // Forwarding is independent of stall/flush state.
    assign forward_a_e = fwd_sel(rs_e, writereg_m, regwrite_m, writereg_w, regwrite_w);
    assign forward_b_e = fwd_sel(rt_e, writereg_m, regwrite_m, writereg_w, regwrite_w);
    assign forward_a_d = reg_match(rs_d, writereg_m, regwrite_m);
    assign forward_b_d = reg_match(rt_d, writereg_m, regwrite_m);

    // Load in E feeding D cannot be forwarded in time.
    assign lw_stall = memtoreg_e &&
                      (reg_match(rs_d, writereg_e, regwrite_e) ||
                       reg_match(rt_d, writereg_e, regwrite_e));

    // Branch compares in D: any E result, or a load still in M, is too late.
    assign br_stall = branch_d &&
                      (reg_match(rs_d, writereg_e, regwrite_e) ||
                       reg_match(rt_d, writereg_e, regwrite_e) ||
                       (memtoreg_m && (reg_match(rs_d, writereg_m, regwrite_m) ||
                                       reg_match(rt_d, writereg_m, regwrite_m))));

    div_stall_fsm #(.DIV_CYCLES(DIV_CYCLES)) u_div_fsm (
        .clk   (clk),
        .rst   (rst),
        .start (div_start_e),
        .abort (except_m),
        .busy  (div_stall)
    );

    assign div_busy = div_stall;

    // Stall/flush priority: exception, divider, load-use/branch.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_m = 1'b0;
        flush_w = 1'b0;
        if (except_m) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_m = 1'b1;
            flush_w = 1'b1;
        end else if (div_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
        end else if (lw_stall || br_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

endmodule
